// File: rtl/booth_issue.sv
// booth_issue: issue/collect stage wrapped around the sequential Booth multiplier.
// Ports: in_* operand handshake, mul_* multiplier drive/return, out_* result handshake, busy.
module booth_issue #(
   parameter int W       = 4,
   parameter int TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   output logic           mul_rstN,
   input  logic [2*W-1:0] mul_res,
   input  logic           mul_done,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_res,
   output logic           out_err,
   output logic           busy
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      GUARD,
      WAIT
   } state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [W-1:0]   a_n, b_n;
   logic           rstn_n;
   logic           ov_n;
   logic [2*W-1:0] res_n;
   logic           err_n;
   logic           buf_free;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign buf_free = !out_valid || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_rstN  <= 1'b0;
         out_valid <= 1'b0;
         out_res   <= '0;
         out_err   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         mul_a     <= a_n;
         mul_b     <= b_n;
         mul_rstN  <= rstn_n;
         out_valid <= ov_n;
         out_res   <= res_n;
         out_err   <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      a_n     = mul_a;
      b_n     = mul_b;
      rstn_n  = 1'b1;
      ov_n    = out_valid;
      res_n   = out_res;
      err_n   = out_err;

      // Drain first; a reload below overrides it on the same edge.
      if (out_valid && out_ready)
         ov_n = 1'b0;

      unique case (state)
         IDLE: begin
            if (in_valid) begin
               a_n     = in_a;
               b_n     = in_b;
               rstn_n  = 1'b0;
               cnt_n   = '0;
               state_n = LAUNCH;
            end
         end
         LAUNCH: state_n = GUARD;
         // done may still be high from the previous product here.
         GUARD:  state_n = WAIT;
         WAIT: begin
            if (cnt != TMAX)
               cnt_n = cnt + 1'b1;
            if (buf_free) begin
               if (mul_done) begin
                  res_n   = mul_res;
                  err_n   = 1'b0;
                  ov_n    = 1'b1;
                  state_n = IDLE;
               end else if (cnt == TMAX) begin
                  res_n   = '0;
                  err_n   = 1'b1;
                  ov_n    = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_booth_issue.sv
// tb_booth_issue: randomized and directed checks of booth_issue
// against a behavioural Booth stub and an in-order result scoreboard.
module tb_booth_issue;

   localparam int W = 4;
   localparam int T = 16;

   logic         clk = 0;
   logic         rst = 1;
   logic         in_valid = 0;
   logic         in_ready;
   logic [W-1:0] in_a = 0;
   logic [W-1:0] in_b = 0;
   logic [W-1:0] mul_a, mul_b;
   logic         mul_rstN;
   logic [7:0]   mul_res = 0;
   logic         mul_done = 0;
   logic         out_valid;
   logic         out_ready = 1;
   logic [7:0]   out_res;
   logic         out_err;
   logic         busy;

   int nvec = 0;
   int nerr = 0;

   // booth stub: 0 normal, 1 done stuck low, 2 done held stale through GUARD
   int mode = 0;
   int force_lat = 0;

   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];

   booth_issue #(.W(W), .TIMEOUT(T)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_rstN(mul_rstN),
      .mul_res(mul_res), .mul_done(mul_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] prod(input logic [3:0] a,
                                       input logic [3:0] b);
      int sa, sb, p;
      sa = int'($signed(a));
      sb = int'($signed(b));
      p  = sa * sb;
      return p[7:0];
   endfunction

   task automatic booth_model();
      int bcnt, lat;
      logic [3:0] ba, bb;
      bcnt = 0; lat = 3; ba = 0; bb = 0;
      forever begin
         @(negedge clk);
         if (!mul_rstN) begin
            bcnt = 0;
            ba = mul_a;
            bb = mul_b;
            if (force_lat != 0) lat = force_lat;
            else if (mode == 2) lat = $urandom_range(3, 6);
            else lat = $urandom_range(1, 6);
            if (mode != 2) mul_done = 0;
         end else begin
            if (bcnt < 100) bcnt++;
            if (mode == 2 && bcnt == 2) mul_done = 0;
            if (mode != 1 && bcnt == lat) begin
               mul_done = 1;
               mul_res = prod(ba, bb);
            end
         end
      end
   endtask

   task automatic monitor();
      logic prev_rst, prev_acc, prev_stall, ps_err;
      logic [7:0] ps_res;
      logic [8:0] e;
      prev_rst = 1; prev_acc = 0; prev_stall = 0;
      ps_err = 0; ps_res = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_rst = 1; prev_acc = 0; prev_stall = 0;
         end else begin
            nvec++;
            if (in_ready !== !busy) begin
               nerr++;
               $display("FAIL ready_vs_busy: in_ready=%b busy=%b", in_ready, busy);
            end
            if (prev_acc) begin
               nvec++;
               if (mul_rstN !== 1'b0) begin
                  nerr++;
                  $display("FAIL launch_pulse: mul_rstN=%b want 0", mul_rstN);
               end
            end else if (!prev_rst) begin
               nvec++;
               if (mul_rstN !== 1'b1) begin
                  nerr++;
                  $display("FAIL extra_low: mul_rstN=%b want 1", mul_rstN);
               end
            end
            if (prev_stall) begin
               nvec++;
               if (out_valid !== 1'b1 || out_res !== ps_res || out_err !== ps_err) begin
                  nerr++;
                  $display("FAIL stall_stable: v=%b res=%h err=%b want v=1 res=%h err=%b",
                           out_valid, out_res, out_err, ps_res, ps_err);
               end
            end
            if (out_valid && out_ready) begin
               nvec++;
               got_q.push_back({out_err, out_res});
               if (exp_q.size() == 0) begin
                  nerr++;
                  $display("FAIL extra_result: res=%h err=%b want none", out_res, out_err);
               end else begin
                  e = exp_q.pop_front();
                  if ({out_err, out_res} !== e) begin
                     nerr++;
                     $display("FAIL result: res=%h err=%b want res=%h err=%b",
                              out_res, out_err, e[7:0], e[8]);
                  end
               end
            end
            if (in_valid && in_ready) begin
               if (mode == 1 && force_lat == 0) exp_q.push_back({1'b1, 8'h00});
               else exp_q.push_back({1'b0, prod(in_a, in_b)});
            end
            prev_acc   = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            ps_res     = out_res;
            ps_err     = out_err;
            prev_rst   = 0;
         end
      end
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b);
      logic r;
      in_valid = 1; in_a = a; in_b = b;
      for (int i = 0; i < 300; i++) begin
         r = in_ready;
         @(posedge clk); #1;
         if (r) break;
         if (i == 299) begin
            nvec++; nerr++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
         end
      end
      in_valid = 0;
      in_a = $urandom; in_b = $urandom;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (exp_q.size() == 0 && !busy && !out_valid) return;
      end
      nvec++; nerr++;
      $display("FAIL drain_%s: pending=%0d busy=%b want 0 0", tag, exp_q.size(), busy);
   endtask

   task automatic test_reset();
      rst = 1;
      #12;
      nvec++;
      if ({mul_rstN, mul_a, mul_b, out_valid, out_res, out_err, busy, in_ready} !==
          {1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL reset_vals: rstN=%b a=%h b=%h v=%b res=%h err=%b busy=%b rdy=%b",
                  mul_rstN, mul_a, mul_b, out_valid, out_res, out_err, busy, in_ready);
      end
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      nvec++;
      if (mul_rstN !== 1'b1) begin
         nerr++;
         $display("FAIL reset_release: mul_rstN=%b want 1", mul_rstN);
      end
   endtask

   task automatic test_directed();
      logic [7:0] want[4];
      int base;
      want[0] = 8'h23; want[1] = 8'h14; want[2] = 8'hEE; want[3] = 8'hD6;
      base = got_q.size();
      mode = 0; out_ready = 1;
      send(4'(-7), 4'(-5));
      send(4'd4, 4'd5);
      send(4'(-3), 4'd6);
      send(4'd7, 4'(-6));
      wait_idle("directed");
      for (int i = 0; i < 4; i++) begin
         nvec++;
         if (got_q.size() <= base + i) begin
            nerr++;
            $display("FAIL directed_%0d: missing want %h", i, want[i]);
         end else if (got_q[base+i] !== {1'b0, want[i]}) begin
            nerr++;
            $display("FAIL directed_%0d: got %h want %h", i, got_q[base+i], {1'b0, want[i]});
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      base = got_q.size();
      mode = 0; out_ready = 0;
      send(4'd3, 4'd2);
      send(4'(-8), 4'(-8));
      repeat (T + 10) @(posedge clk);
      #1;
      nvec++;
      if (in_ready !== 0 || busy !== 1 || out_valid !== 1 || out_res !== 8'h06) begin
         nerr++;
         $display("FAIL bp_stall: rdy=%b busy=%b v=%b res=%h want 0 1 1 06",
                  in_ready, busy, out_valid, out_res);
      end
      out_ready = 1;
      wait_idle("bp");
      nvec++;
      if (got_q.size() != base + 2) begin
         nerr++;
         $display("FAIL bp_count: got %0d want 2", got_q.size() - base);
      end else if (got_q[base+1] !== 9'h040) begin
         nerr++;
         $display("FAIL bp_second: got %h want 040", got_q[base+1]);
      end
   endtask

   task automatic test_stale_done();
      int base;
      mode = 0; out_ready = 1;
      send(4'd3, 4'd3);
      wait_idle("stale0");
      base = got_q.size();
      mode = 2;
      send(4'(-2), 4'd5);
      wait_idle("stale1");
      nvec++;
      if (got_q.size() != base + 1 || got_q[base] !== 9'h0F6) begin
         nerr++;
         $display("FAIL stale: got %h want 0F6", got_q.size() > base ? got_q[base] : 9'h1FF);
      end
      mode = 0;
   endtask

   task automatic test_timeout();
      int n;
      mode = 1; out_ready = 1;
      n = 0;
      send(4'd5, 4'd5);
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin n = i; break; end
      end
      nvec++;
      if (n != T + 3 || out_err !== 1 || out_res !== 8'h00) begin
         nerr++;
         $display("FAIL timeout: edges=%0d err=%b res=%h want %0d 1 00",
                  n, out_err, out_res, T + 3);
      end
      wait_idle("to");
      mode = 0;
      send(4'd2, 4'(-3));
      wait_idle("post_to");
      nvec++;
      if (got_q[$] !== 9'h0FA) begin
         nerr++;
         $display("FAIL after_timeout: got %h want 0FA", got_q[$]);
      end
   endtask

   task automatic test_done_vs_timeout();
      mode = 0; force_lat = T + 2; out_ready = 1;
      send(4'd6, 4'd7);
      wait_idle("tie");
      force_lat = 0;
      nvec++;
      if (got_q[$] !== 9'h02A) begin
         nerr++;
         $display("FAIL done_wins: got %h want 02A", got_q[$]);
      end
   endtask

   task automatic test_reset_mid();
      mode = 1; out_ready = 1;
      send(4'd1, 4'd1);
      repeat (4) @(posedge clk);
      #2;
      rst = 1;
      #1;
      nvec++;
      if (mul_rstN !== 0 || out_valid !== 0 || busy !== 0) begin
         nerr++;
         $display("FAIL async_rst: rstN=%b v=%b busy=%b want 0 0 0", mul_rstN, out_valid, busy);
      end
      exp_q.delete();
      mode = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      @(posedge clk); #1;
      send(4'd4, 4'd5);
      wait_idle("rst_mid");
      nvec++;
      if (got_q[$] !== 9'h014) begin
         nerr++;
         $display("FAIL post_rst: got %h want 014", got_q[$]);
      end
   endtask

   task automatic test_random();
      int base, n;
      logic done_s;
      base = got_q.size();
      n = 40; done_s = 0; mode = 0;
      fork
         begin
            for (int i = 0; i < n; i++) begin
               send(4'($urandom), 4'($urandom));
               if ($urandom_range(0, 2) == 0) begin
                  @(posedge clk); #1;
               end
            end
            done_s = 1;
         end
         begin
            for (int j = 0; j < 5000 && !done_s; j++) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1;
      wait_idle("rand");
      nvec++;
      if (got_q.size() != base + n) begin
         nerr++;
         $display("FAIL rand_count: got %0d want %0d", got_q.size() - base, n);
      end
   endtask

   initial begin
      fork
         booth_model();
         monitor();
      join_none
      test_reset();
      test_directed();
      test_backpressure();
      test_stale_done();
      test_timeout();
      test_done_vs_timeout();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
